csr_conv_scheduler: RTL and testbench

//  Sequencer for scatter-style sparse convolution on CSR-encoded images. After the CSR encoder

---
 rtl/csr_pkg.sv | 28 ++
 rtl/csr_conv_scheduler_tap.sv | 47 ++++
 rtl/csr_conv_scheduler.sv | 164 ++++++++++++++++
 tb/tb_csr_conv_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types for the CSR encoder and the sparse conv scheduler.
// Holds FSM encoding, geometry constants and the stored entry layout.
package csr_pkg;

  localparam int COL_W   = 8;
  localparam int WORD_W  = 8;
  localparam int DWORD_W = 16;
  localparam int K       = 5;
  localparam int I       = 28;
  localparam int O       = I - K + 1;
  localparam int TAPS    = K * K;
  localparam int KIDX_W  = $clog2(TAPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] value;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  row;
  } entry_t;

endpackage

// File: rtl/csr_conv_scheduler_tap.sv
// Nested kr/kc kernel tap counter (kr outer, kc inner) with clear/advance.
// Ports: clk, rst (async low), clear, advance -> kr, kc, kidx, last.
module csr_tap_counter #(
  parameter int K = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        advance,
  output logic [$clog2(K)-1:0]        kr,
  output logic [$clog2(K)-1:0]        kc,
  output logic [$clog2(K*K)-1:0]      kidx,
  output logic                        last
);

  localparam int KR_W   = $clog2(K);
  localparam int KIDX_W = $clog2(K*K);

  localparam logic [KR_W-1:0] KMAX = KR_W'(K - 1);

  logic kc_wrap;

  assign kc_wrap = (kc == KMAX);
  assign last    = kc_wrap && (kr == KMAX);

  // kidx runs alongside kr/kc so no multiplier is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kr   <= '0;
      kc   <= '0;
      kidx <= '0;
    end else if (clear) begin
      kr   <= '0;
      kc   <= '0;
      kidx <= '0;
    end else if (advance) begin
      if (kc_wrap) begin
        kc <= '0;
        kr <= (kr == KMAX) ? '0 : kr + 1'b1;
      end else begin
        kc <= kc + 1'b1;
      end
      kidx <= last ? '0 : kidx + 1'b1;
    end
  end

endmodule

// File: rtl/csr_conv_scheduler.sv
// Walks the CSR nonzero list and issues one MAC op per in-window kernel tap.
// Ports: start/nnz job control, rd_* list read, op_* valid/ready, busy/done/err.
module csr_conv_scheduler
  import csr_pkg::*;
#(
  parameter int col_length         = COL_W,
  parameter int word_length        = WORD_W,
  parameter int double_word_length = DWORD_W,
  parameter int kernel_size        = K,
  parameter int image_size         = I
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [double_word_length-1:0]          nnz,
  output logic                                   rd_en,
  output logic [double_word_length-1:0]          rd_addr,
  input  logic [word_length-1:0]                 rd_value,
  input  logic [col_length-1:0]                  rd_col,
  input  logic [col_length-1:0]                  rd_row,
  output logic                                   op_valid,
  input  logic                                   op_ready,
  output logic [word_length-1:0]                 op_value,
  output logic [col_length-1:0]                  op_orow,
  output logic [col_length-1:0]                  op_ocol,
  output logic [$clog2(kernel_size*kernel_size)-1:0] op_kidx,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int O_SZ   = image_size - kernel_size + 1;
  localparam int MAXN   = image_size * image_size;
  localparam int KR_W   = $clog2(kernel_size);
  localparam int KIDX_W = $clog2(kernel_size*kernel_size);
  localparam int DW     = double_word_length;
  localparam int CW     = col_length;

  state_t state, state_nxt;

  logic [DW-1:0]          idx, idx_nxt;
  logic [DW-1:0]          nnz_q, nnz_nxt;
  logic [word_length-1:0] val_q;
  logic [CW-1:0]          row_q;
  logic [CW-1:0]          col_q;
  logic                   err_nxt;
  logic                   tap_clr;
  logic                   tap_adv;
  logic                   in_range;
  logic [DW:0]            idx_inc;

  logic [KR_W-1:0]   kr;
  logic [KR_W-1:0]   kc;
  logic [KIDX_W-1:0] kidx;
  logic              tap_last;

  csr_tap_counter #(
    .K(kernel_size)
  ) u_tap (
    .clk    (clk),
    .rst    (rst),
    .clear  (tap_clr),
    .advance(tap_adv),
    .kr     (kr),
    .kc     (kc),
    .kidx   (kidx),
    .last   (tap_last)
  );

  // Window check done as row in [kr, kr+O) so nothing underflows.
  logic [CW:0] row_x, col_x, kr_x, kc_x, o_x;

  assign row_x = {1'b0, row_q};
  assign col_x = {1'b0, col_q};
  assign kr_x  = (CW+1)'(kr);
  assign kc_x  = (CW+1)'(kc);
  assign o_x   = (CW+1)'(O_SZ);

  assign in_range = (row_x >= kr_x) && (col_x >= kc_x) &&
                    (row_x < kr_x + o_x) && (col_x < kc_x + o_x);

  assign idx_inc = {1'b0, idx} + 1'b1;

  assign op_valid = (state == S_ISSUE) && in_range;
  assign op_value = op_valid ? val_q : '0;
  assign op_orow  = op_valid ? row_q - CW'(kr) : '0;
  assign op_ocol  = op_valid ? col_q - CW'(kc) : '0;
  assign op_kidx  = op_valid ? kidx : '0;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    nnz_nxt   = nnz_q;
    err_nxt   = 1'b0;
    tap_clr   = 1'b0;
    tap_adv   = 1'b0;
    unique case (state)
      S_IDLE: begin
        tap_clr = 1'b1;
        if (start) begin
          if (nnz == '0) begin
            state_nxt = S_DONE;
          end else if (nnz > DW'(MAXN)) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = S_FETCH;
            idx_nxt   = '0;
            nnz_nxt   = nnz;
          end
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        tap_clr   = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // Out-of-window taps still burn their cycle.
        tap_adv = !in_range || op_ready;
        if (tap_adv && tap_last) begin
          if (idx_inc < {1'b0, nnz_q}) begin
            state_nxt = S_FETCH;
            idx_nxt   = idx_inc[DW-1:0];
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      nnz_q   <= '0;
      val_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      nnz_q   <= nnz_nxt;
      rd_en   <= (state_nxt == S_FETCH);
      rd_addr <= (state_nxt == S_FETCH) ? idx_nxt : '0;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
      err     <= err_nxt;
      if (state == S_WAIT) begin
        val_q <= rd_value;
        row_q <= rd_row;
        col_q <= rd_col;
      end
    end
  end

endmodule

// File: tb/tb_csr_conv_scheduler.sv
// Scoreboard bench for csr_conv_scheduler with a tap-list reference model.
// Monitor pops expected ops on each accepted handshake.
module tb_csr_conv_scheduler;

  localparam int K = 5;
  localparam int I = 28;
  localparam int O = I - K + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] nnz = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_value = '0;
  logic [7:0]  rd_col = '0;
  logic [7:0]  rd_row = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [7:0]  op_value;
  logic [7:0]  op_orow;
  logic [7:0]  op_ocol;
  logic [4:0]  op_kidx;
  logic        busy;
  logic        done;
  logic        err;

  csr_conv_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .nnz     (nnz),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_value(rd_value),
    .rd_col  (rd_col),
    .rd_row  (rd_row),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_value(op_value),
    .op_orow (op_orow),
    .op_ocol (op_ocol),
    .op_kidx (op_kidx),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int r;
    int c;
    int k;
  } op_t;

  op_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int mode = 0;
  int stall_left = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;

  logic [7:0] mem_v[0:63];
  logic [7:0] mem_r[0:63];
  logic [7:0] mem_c[0:63];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // List memory: answers the read during the rd_en cycle, held through WAIT.
  always @(negedge clk) begin
    if (rst && rd_en) begin
      rd_value = mem_v[rd_addr[5:0]];
      rd_row   = mem_r[rd_addr[5:0]];
      rd_col   = mem_c[rd_addr[5:0]];
    end
  end

  logic        hold = 1'b0;
  logic [28:0] held;

  // Monitor: pick ready, check hold stability, pop on acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      hold     = 1'b0;
      op_ready = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", int'(op_valid), 1);
        chk("hold_fields", int'({op_value, op_orow, op_ocol, op_kidx}), int'(held));
      end
      case (mode)
        1: op_ready = ($urandom_range(0, 3) != 0);
        2: begin
          op_ready = 1'b1;
          if (op_valid && op_kidx == 5'd7 && stall_left > 0) begin
            op_ready = 1'b0;
            stall_left--;
          end
        end
        default: op_ready = 1'b1;
      endcase
      if (op_valid && !op_ready) begin
        hold = 1'b1;
        held = {op_value, op_orow, op_ocol, op_kidx};
        stall_cnt++;
      end else begin
        hold = 1'b0;
      end
      if (op_valid && op_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_op: got kidx %0d orow %0d ocol %0d, expected none",
                   op_kidx, op_orow, op_ocol);
        end else begin
          op_t e;
          e = q.pop_front();
          chk("op_value", int'(op_value), e.v);
          chk("op_orow", int'(op_orow), e.r);
          chk("op_ocol", int'(op_ocol), e.c);
          chk("op_kidx", int'(op_kidx), e.k);
        end
      end
      if (done) done_cnt++;
      if (rd_en) rd_cnt++;
    end
  end

  // Reference: every tap whose output coordinate lands in the O x O window.
  task automatic model(input int n);
    for (int e = 0; e < n; e++) begin
      for (int kr = 0; kr < K; kr++) begin
        for (int kc = 0; kc < K; kc++) begin
          op_t o;
          o.v = int'(mem_v[e]);
          o.r = int'(mem_r[e]) - kr;
          o.c = int'(mem_c[e]) - kc;
          o.k = kr * K + kc;
          if (o.r >= 0 && o.r < O && o.c >= 0 && o.c < O) q.push_back(o);
        end
      end
    end
  endtask

  task automatic run_job(input int n, input int md, input bit ign);
    int s0, d0, r0, cyc;
    bit got;
    model(n);
    mode       = md;
    stall_left = 3;
    s0 = stall_cnt;
    d0 = done_cnt;
    r0 = rd_cnt;
    start = 1'b1;
    nnz   = 16'(n);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20000) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
      end
      if (ign && cyc == 5) begin
        start = 1'b1;
        nnz   = 16'd3;
      end
      if (ign && cyc == 6) start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
    chk("done_seen", int'(got), 1);
    chk("job_cycles", cyc, 27 * n + (stall_cnt - s0));
    @(negedge clk);
    chk("done_width", int'(done), 0);
    chk("busy_end", int'(busy), 0);
    @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("ops_left", q.size(), 0);
    chk("reads", rd_cnt - r0, n);
    q.delete();
  endtask

  task automatic set_entry(input int e, input int r, input int c, input int v);
    mem_r[e] = 8'(r);
    mem_c[e] = 8'(c);
    mem_v[e] = 8'(v);
  endtask

  initial begin
    int d0;
    for (int e = 0; e < 64; e++) set_entry(e, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_op_fields", int'({op_value, op_orow, op_ocol, op_kidx}), 0);
    rst = 1'b1;
    @(negedge clk);

    run_job(0, 0, 1'b0);

    set_entry(0, 10, 10, 3);
    run_job(1, 0, 1'b0);
    set_entry(0, 0, 0, 7);
    run_job(1, 0, 1'b0);
    set_entry(0, 27, 27, 9);
    run_job(1, 0, 1'b0);
    set_entry(0, 10, 10, 5);
    run_job(1, 2, 1'b0);

    start = 1'b1;
    nnz   = 16'd785;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    @(negedge clk);
    chk("err_clear", int'(err), 0);
    chk("err_busy2", int'(busy), 0);

    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int e = 0; e < n; e++)
        set_entry(e, $urandom_range(0, I - 1), $urandom_range(0, I - 1),
                  $urandom_range(0, 255));
      run_job(n, (j < 2) ? 0 : 1, j == 3);
    end

    for (int e = 0; e < 4; e++) set_entry(e, 12, 12, e + 1);
    model(4);
    mode = 0;
    start = 1'b1;
    nnz   = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (27 + 2 + 8) @(negedge clk);
    chk("pre_rst_valid", int'(op_valid), 1);
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    q.delete();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rd", int'({rd_en, rd_addr}), 0);
    chk("abort_op", int'({op_valid, op_value, op_orow, op_ocol, op_kidx}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", int'(busy), 0);
    set_entry(0, 5, 20, 11);
    run_job(1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
